// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - execute-stage forwarding, load-use and scoreboard stall control
// Optional stall counter built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter int REG_SELECT = 5,
    parameter int N_READ     = 2,
    parameter int N_STAGES   = 2,
    parameter int ZERO_REG   = 1,
    parameter int SRC_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [N_READ-1:0]              i_read_valid,
    input  logic [N_READ*REG_SELECT-1:0]   i_read_select,
    input  logic [N_STAGES-1:0]            i_is_write,
    input  logic [N_STAGES*REG_SELECT-1:0] i_write_select,
    input  logic                           i_is_load,
    input  logic                           i_mc_issue,
    input  logic [REG_SELECT-1:0]          i_mc_issue_select,
    input  logic                           i_mc_done,
    input  logic [REG_SELECT-1:0]          i_mc_done_select,
    output logic [N_READ-1:0]              o_forward,
    output logic [N_READ*SRC_W-1:0]        o_forward_src,
    output logic                           o_stall,
    output logic [1:0]                     o_stall_cause,
    output logic [(1<<REG_SELECT)-1:0]     o_pending,
    output logic                           o_err,
    output logic [CNT_WIDTH-1:0]           o_stall_cnt
);

    localparam int NREG = 1 << REG_SELECT;

    logic             load_haz;
    logic             sb_haz;
    logic             issue_ok;
    logic             set_conflict;
    logic [NREG-1:0]  pending_next;

    always_comb begin
        o_forward     = '0;
        o_forward_src = '0;
        load_haz      = 1'b0;
        sb_haz        = 1'b0;
        for (int k = 0; k < N_READ; k++) begin
            logic [REG_SELECT-1:0] rsel;
            logic                  active;
            rsel   = i_read_select[k*REG_SELECT +: REG_SELECT];
            active = i_read_valid[k] && !(ZERO_REG != 0 && rsel == '0);
            // Walk oldest to youngest so the lowest matching source is the one left standing.
            for (int s = N_STAGES - 1; s >= 0; s--) begin
                if (active && i_is_write[s] &&
                    i_write_select[s*REG_SELECT +: REG_SELECT] == rsel) begin
                    o_forward[k]                   = 1'b1;
                    o_forward_src[k*SRC_W +: SRC_W] = SRC_W'(s);
                    if (s == 0 && i_is_load)
                        load_haz = 1'b1;
                end
            end
            if (active && o_pending[rsel])
                sb_haz = 1'b1;
        end
        o_stall       = load_haz || sb_haz;
        o_stall_cause = sb_haz ? 2'b10 : (load_haz ? 2'b01 : 2'b00);
    end

    always_comb begin
        issue_ok     = i_mc_issue && !(ZERO_REG != 0 && i_mc_issue_select == '0);
        set_conflict = issue_ok && o_pending[i_mc_issue_select] &&
                       !(i_mc_done && i_mc_done_select == i_mc_issue_select);
        pending_next = o_pending;
        if (i_mc_done)
            pending_next[i_mc_done_select] = 1'b0;
        // Set after clear: an issue and done to the same register leaves it pending.
        if (issue_ok)
            pending_next[i_mc_issue_select] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pending <= '0;
            o_err     <= 1'b0;
        end else begin
            o_pending <= pending_next;
            if (set_conflict)
                o_err <= 1'b1;
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_stall_cnt <= '0;
        else if (o_stall && o_stall_cnt != {CNT_WIDTH{1'b1}})
            o_stall_cnt <= o_stall_cnt + 1'b1;
    end
`else
    assign o_stall_cnt = '0;
`endif

endmodule
